// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// Operands and control are registered onto the ALU; the result returns through a per-requester handshake.
module alu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2,
    input  logic [NUM_REQ*4-1:0]          req_control,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_error,
    output logic [DATA_WIDTH-1:0]         alu_data_1,
    output logic [DATA_WIDTH-1:0]         alu_data_2,
    output logic [3:0]                    alu_control,
    input  logic [DATA_WIDTH-1:0]         alu_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CTRL_NOP = 4'b1111;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic code_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0110: code_legal = 1'b1;
            default:                            code_legal = 1'b0;
        endcase
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic [IDX_W-1:0]        last_grant_r;
    logic [IDX_W-1:0]        owner_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   alu_data_1_r;
    logic [DATA_WIDTH-1:0]   alu_data_2_r;
    logic [3:0]              alu_control_r;
    logic [NUM_REQ-1:0]      rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_result_r;
    logic                    rsp_error_r;

    logic [DATA_WIDTH-1:0]   d1_arr_s [NUM_REQ];
    logic [DATA_WIDTH-1:0]   d2_arr_s [NUM_REQ];
    logic [3:0]              ctrl_arr_s [NUM_REQ];
    logic                    win_found_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [IDX_W-1:0]        cand_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic                    fire_s;
    logic [3:0]              win_code_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign d1_arr_s[g]   = req_data_1[g*DATA_WIDTH +: DATA_WIDTH];
        assign d2_arr_s[g]   = req_data_2[g*DATA_WIDTH +: DATA_WIDTH];
        assign ctrl_arr_s[g] = req_control[g*4 +: 4];
    end

    // Round-robin winner search; walking offsets downwards lets the nearest valid requester after last_grant win.
    always_comb begin
        win_found_s = |req_valid;
        win_idx_s   = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s    = IDX_W'((int'(last_grant_r) + k) % NUM_REQ);
            win_idx_s = req_valid[cand_s] ? cand_s : win_idx_s;
        end
    end

    // Grant is only offered while idle, one-hot on the winner.
    always_comb begin
        grant_s    = ONE_HOT_0 << win_idx_s;
        fire_s     = (state_r == ST_IDLE) && win_found_s;
        win_code_s = ctrl_arr_s[win_idx_s];
        if (fire_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic for the issue / execute / respond sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) state_s = ST_EXEC;
                else        state_s = ST_IDLE;
            end
            ST_EXEC: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready[owner_r]) state_s = ST_IDLE;
                else                    state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: issue onto the ALU, capture the result, then hold the response until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r  <= LAST_RST;
            owner_r       <= {IDX_W{1'b0}};
            err_r         <= 1'b0;
            alu_data_1_r  <= {DATA_WIDTH{1'b0}};
            alu_data_2_r  <= {DATA_WIDTH{1'b0}};
            alu_control_r <= CTRL_NOP;
            rsp_valid_r   <= {NUM_REQ{1'b0}};
            rsp_result_r  <= {DATA_WIDTH{1'b0}};
            rsp_error_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fire_s) begin
                        alu_data_1_r <= d1_arr_s[win_idx_s];
                        alu_data_2_r <= d2_arr_s[win_idx_s];
                        owner_r      <= win_idx_s;
                        // An illegal code never reaches the ALU, which therefore sees no transition.
                        if (code_legal(win_code_s)) begin
                            alu_control_r <= win_code_s;
                            err_r         <= 1'b0;
                        end else begin
                            alu_control_r <= CTRL_NOP;
                            err_r         <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_result_r  <= err_r ? {DATA_WIDTH{1'b0}} : alu_result;
                    rsp_error_r   <= err_r;
                    rsp_valid_r   <= ONE_HOT_0 << owner_r;
                    alu_control_r <= CTRL_NOP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner_r]) begin
                        last_grant_r <= owner_r;
                        rsp_valid_r  <= {NUM_REQ{1'b0}};
                        rsp_error_r  <= 1'b0;
                    end
                end
                default: begin
                    alu_control_r <= CTRL_NOP;
                end
            endcase
        end
    end

    assign alu_data_1  = alu_data_1_r;
    assign alu_data_2  = alu_data_2_r;
    assign alu_control = alu_control_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_error   = rsp_error_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level round-robin / ALU reference model.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam logic [3:0] NOP = 4'b1111;
    localparam int QD = 128;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data_1;
    logic [N*W-1:0]   req_data_2;
    logic [N*4-1:0]   req_control;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_result;
    logic             rsp_error;
    logic [W-1:0]     alu_data_1;
    logic [W-1:0]     alu_data_2;
    logic [3:0]       alu_control;
    logic [W-1:0]     alu_result;

    logic [W-1:0]     d1_tb [N];
    logic [W-1:0]     d2_tb [N];
    logic [3:0]       c_tb  [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data_1[g*W +: W]  = d1_tb[g];
        assign req_data_2[g*W +: W]  = d2_tb[g];
        assign req_control[g*4 +: 4] = c_tb[g];
    end

    alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data_1(req_data_1), .req_data_2(req_data_2), .req_control(req_control),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_control(alu_control),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic legal(input logic [3:0] c);
        return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0110);
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return {W{1'b0}};
        endcase
    endfunction

    // External ALU behaviour: NOP and anything else unknown yields zero.
    always_comb alu_result = ref_alu(alu_data_1, alu_data_2, alu_control);

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [3:0] c; } op_t;
    typedef struct { int owner; logic [W-1:0] a; logic [W-1:0] b; logic [3:0] c; logic [W-1:0] res; logic err; } exp_t;

    op_t  ops [N][QD];
    int   head [N];
    int   tail [N];
    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;
    int rr_mode  = 0;
    int m_phase  = 0;
    int m_last   = N - 1;
    int m_owner  = 0;
    logic have_cur = 1'b0;
    exp_t cur;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = {N{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: first valid requester after the last one served, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i] = 1'b1;
                d1_tb[i] = ops[i][head[i] % QD].a;
                d2_tb[i] = ops[i][head[i] % QD].b;
                c_tb[i]  = ops[i][head[i] % QD].c;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic add_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        ops[i][tail[i] % QD].a = a;
        ops[i][tail[i] % QD].b = b;
        ops[i][tail[i] % QD].c = c;
        tail[i]++;
        present();
    endtask

    task automatic rand_op(input int i);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   c;
        a = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       c = 4'b0000;
            1:       c = 4'b0001;
            2:       c = 4'b0010;
            3:       c = 4'b0110;
            default: c = 4'($urandom);
        endcase
        add_op(i, a, b, c);
    endtask

    // One clock: record accepted requests into the scoreboard, then drive the next inputs.
    task automatic step();
        logic [N-1:0] fired;
        exp_t e;
        @(negedge clk);
        fired = rst_n ? (req_valid & req_ready) : {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                e.owner = i;
                e.a     = ops[i][head[i] % QD].a;
                e.b     = ops[i][head[i] % QD].b;
                e.c     = ops[i][head[i] % QD].c;
                e.err   = !legal(e.c);
                e.res   = e.err ? {W{1'b0}} : ref_alu(e.a, e.b, e.c);
                sb.push_back(e);
                head[i]++;
            end
        end
        @(posedge clk);
        #1;
        present();
        case (rr_mode)
            0:       rsp_ready = {N{1'b1}};
            1:       rsp_ready = {N{1'b0}};
            default: rsp_ready = N'($urandom);
        endcase
    endtask

    function automatic logic all_idle();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return (sb.size() == 0) && (m_phase == 0);
    endfunction

    task automatic wait_idle(input string name);
        for (int c = 0; c < 2000; c++) begin
            if (all_idle()) break;
            step();
        end
        chk(name, {63'd0, all_idle()}, 64'd1);
    endtask

    task automatic wait_rsp(input string name);
        for (int c = 0; c < 50; c++) begin
            if (rsp_valid != {N{1'b0}}) break;
            step();
        end
        chk(name, {63'd0, rsp_valid != {N{1'b0}}}, 64'd1);
    endtask

    // Monitor: follows the protocol at transaction level and pops the scoreboard when a response appears.
    initial begin
        logic [N-1:0] exp_rdy;
        int w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase  = 0;
                m_last   = N - 1;
                have_cur = 1'b0;
                sb.delete();
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_error", rsp_error, 0);
                chk("rst_rsp_result", rsp_result, 0);
                chk("rst_alu_control", alu_control, NOP);
                chk("rst_alu_data", alu_data_1 | alu_data_2, 0);
            end else begin
                case (m_phase)
                    0: begin
                        w = rr_pick(req_valid, m_last);
                        exp_rdy = (w >= 0) ? onehot(w) : {N{1'b0}};
                        chk("req_ready_grant", req_ready, exp_rdy);
                        chk("idle_rsp_valid", rsp_valid, 0);
                        chk("idle_alu_control", alu_control, NOP);
                        if (w >= 0) begin
                            m_owner = w;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        chk("exec_req_ready", req_ready, 0);
                        chk("exec_rsp_valid", rsp_valid, 0);
                        if (sb.size() == 0) begin
                            chk("exec_sb_entry", 0, 1);
                        end else begin
                            chk("exec_owner", sb[0].owner, m_owner);
                            chk("exec_alu_data_1", alu_data_1, sb[0].a);
                            chk("exec_alu_data_2", alu_data_2, sb[0].b);
                            chk("exec_alu_control", alu_control, legal(sb[0].c) ? sb[0].c : NOP);
                        end
                        m_phase = 2;
                    end
                    default: begin
                        if (!have_cur && sb.size() > 0) begin
                            cur = sb.pop_front();
                            have_cur = 1'b1;
                        end
                        chk("resp_req_ready", req_ready, 0);
                        chk("resp_alu_control", alu_control, NOP);
                        if (have_cur) begin
                            chk("rsp_valid", rsp_valid, onehot(cur.owner));
                            chk("rsp_result", rsp_result, cur.res);
                            chk("rsp_error", rsp_error, cur.err);
                        end
                        if (rsp_ready[m_owner]) begin
                            m_last   = m_owner;
                            m_phase  = 0;
                            have_cur = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = {N{1'b0}};
        rsp_ready = {N{1'b1}};
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            d1_tb[i] = {W{1'b0}};
            d2_tb[i] = {W{1'b0}};
            c_tb[i]  = NOP;
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single ADD from requester 0.
        add_op(0, 64'd5, 64'd7, 4'b0010);
        wait_idle("drain_single_add");

        // Back-to-back SUB from requester 2, second one wraps.
        add_op(2, 64'd10, 64'd3, 4'b0110);
        add_op(2, 64'd1, 64'd2, 4'b0110);
        wait_idle("drain_b2b_sub");

        // Fresh reset, then all requesters contend: order 0,1,2,3,0,...
        @(posedge clk);
        #3 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) rand_op(i);
        end
        wait_idle("drain_contend");

        // Illegal code from requester 1.
        add_op(1, 64'h1234, 64'h5678, 4'b0111);
        wait_idle("drain_illegal");

        // Response stalled while requester 3 waits.
        rr_mode = 1;
        add_op(0, 64'hFF00, 64'h0FF0, 4'b0000);
        wait_rsp("stall_rsp_seen");
        add_op(3, 64'hA0, 64'h0B, 4'b0001);
        repeat (5) step();
        rr_mode = 0;
        wait_idle("drain_stall");

        // Reset pulse during RESP drops the response; requester 0 wins first afterwards.
        rr_mode = 1;
        add_op(1, 64'd100, 64'd1, 4'b0010);
        wait_rsp("rst_rsp_seen");
        add_op(0, 64'd3, 64'd4, 4'b0010);
        add_op(2, 64'd9, 64'd8, 4'b0110);
        add_op(3, 64'd6, 64'd5, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_drop_rsp_valid", rsp_valid, 0);
        chk("async_drop_alu_control", alu_control, NOP);
        chk("async_drop_rsp_result", rsp_result, 0);
        step();
        step();
        rst_n = 1'b1;
        rr_mode = 0;
        wait_idle("drain_after_reset");

        // Random traffic with random response back-pressure.
        rr_mode = 2;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (head[i] == tail[i] && $urandom_range(0, 2) == 0) rand_op(i);
            end
            step();
        end
        wait_idle("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
